// File: rtl/b10_stim_pkg.sv
// Shared types and opcode field positions for the b10 stimulus sequencer.
package b10_stim_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int R_BTN_B = 0;
    localparam int G_BTN_B = 1;
    localparam int KEY_B   = 2;
    localparam int START_B = 3;
    localparam int TEST_B  = 4;
    localparam int RTS_B   = 5;
    localparam int RTR_B   = 6;
    localparam int VIN_LSB = 7;
    localparam int VIN_MSB = 10;
    localparam int OBS_B   = 11;

    typedef struct packed {
        logic       obs;
        logic [3:0] v_in;
        logic       rtr;
        logic       rts;
        logic       test;
        logic       start_o;
        logic       key;
        logic       g_button;
        logic       r_button;
    } opcode_t;

endpackage

// File: rtl/b10_stim_sequencer_ram.sv
// Opcode store: one synchronous write port, combinational read, no reset.
module b10_stim_ram #(
    parameter int DEPTH  = 64,
    parameter int OP_W   = 12,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [OP_W-1:0]   wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [OP_W-1:0]   rdata
);

    logic [OP_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/b10_stim_sequencer.sv
// Opcode replayer driving the b10 voting controller inputs from a host-loaded RAM.
//   state | meaning
//   IDLE  | waiting for start, outputs 0
//   RUN   | stepping pc one word per clock (pause freezes)
//   DONE  | last word replayed, done held until start/abort
module b10_stim_sequencer
    import b10_stim_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int OP_W   = 12,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [OP_W-1:0]   wr_data,
    output logic              wr_err,
    input  logic              start,
    input  logic              abort,
    input  logic              pause,
    input  logic              loop_en,
    input  logic [ADDR_W:0]   run_len,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] pc,
    output logic [7:0]        loop_cnt,
    output logic              r_button,
    output logic              g_button,
    output logic              key,
    output logic              start_o,
    output logic              test,
    output logic              rts,
    output logic              rtr,
    output logic [3:0]        v_in,
    output logic              obs
);

    localparam logic [1:0]    S_IDLE   = 2'(IDLE);
    localparam logic [1:0]    S_RUN    = 2'(RUN);
    localparam logic [1:0]    S_DONE   = 2'(DONE);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [7:0]        loop_cnt_q, loop_cnt_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic              loop_q, loop_d;
    logic [OP_W-1:0]   out_q, out_d;
    logic              wr_err_q, wr_err_d;

    logic [OP_W-1:0]   rd_data;
    opcode_t           rd_word;
    logic [ADDR_W:0]   eff_len;
    logic              last_word;
    logic              ram_we;

    assign ram_we = wr_en && (state_q != S_RUN);

    b10_stim_ram #(
        .DEPTH  (DEPTH),
        .OP_W   (OP_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clock (clock),
        .we    (ram_we),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (pc_q),
        .rdata (rd_data)
    );

    assign rd_word   = opcode_t'(rd_data);
    assign eff_len   = (run_len > DEPTH_L) ? DEPTH_L : run_len;
    assign last_word = ({1'b0, pc_q} == (len_q - (ADDR_W+1)'(1)));

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        loop_cnt_d = loop_cnt_q;
        len_d      = len_q;
        loop_d     = loop_q;
        out_d      = out_q;
        wr_err_d   = wr_en && (state_q == S_RUN);

        if (abort) begin
            state_d = S_IDLE;
            out_d   = '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    // Clearing here makes the final word visible for exactly one cycle.
                    out_d = '0;
                    if (start && (eff_len != '0)) begin
                        state_d    = S_RUN;
                        pc_d       = '0;
                        loop_cnt_d = '0;
                        len_d      = eff_len;
                        loop_d     = loop_en;
                    end
                end
                S_RUN: begin
                    if (!pause) begin
                        out_d = rd_word;
                        if (last_word) begin
                            if (loop_q) begin
                                pc_d = '0;
                                if (loop_cnt_q != 8'hFF) begin
                                    loop_cnt_d = loop_cnt_q + 8'd1;
                                end
                            end else begin
                                state_d = S_DONE;
                            end
                        end else begin
                            pc_d = pc_q + ADDR_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    out_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            loop_cnt_q <= '0;
            len_q      <= '0;
            loop_q     <= 1'b0;
            out_q      <= '0;
            wr_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            loop_cnt_q <= loop_cnt_d;
            len_q      <= len_d;
            loop_q     <= loop_d;
            out_q      <= out_d;
            wr_err_q   <= wr_err_d;
        end
    end

    assign busy     = (state_q == S_RUN);
    assign done     = (state_q == S_DONE);
    assign pc       = pc_q;
    assign loop_cnt = loop_cnt_q;
    assign wr_err   = wr_err_q;
    assign r_button = out_q[R_BTN_B];
    assign g_button = out_q[G_BTN_B];
    assign key      = out_q[KEY_B];
    assign start_o  = out_q[START_B];
    assign test     = out_q[TEST_B];
    assign rts      = out_q[RTS_B];
    assign rtr      = out_q[RTR_B];
    assign v_in     = out_q[VIN_MSB:VIN_LSB];
    assign obs      = out_q[OBS_B];

endmodule

// File: tb/tb_b10_stim_sequencer.sv
// Directed bench for b10_stim_sequencer with a small RAM (DEPTH=8).
module tb_b10_stim_sequencer;

    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;

    logic              clock = 1'b0;
    logic              reset;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [11:0]       wr_data;
    logic              wr_err;
    logic              start, abort, pause, loop_en;
    logic [ADDR_W:0]   run_len;
    logic              busy, done;
    logic [ADDR_W-1:0] pc;
    logic [7:0]        loop_cnt;
    logic              r_button, g_button, key, start_o, test, rts, rtr, obs;
    logic [3:0]        v_in;

    int n_assert = 0;
    int n_fail   = 0;

    logic [11:0] prog [8];
    logic [11:0] outw;

    assign outw = {obs, v_in, rtr, rts, test, start_o, key, g_button, r_button};

    always #5 clock = ~clock;

    b10_stim_sequencer #(.DEPTH(DEPTH), .OP_W(12)) dut (
        .clock    (clock),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_err   (wr_err),
        .start    (start),
        .abort    (abort),
        .pause    (pause),
        .loop_en  (loop_en),
        .run_len  (run_len),
        .busy     (busy),
        .done     (done),
        .pc       (pc),
        .loop_cnt (loop_cnt),
        .r_button (r_button),
        .g_button (g_button),
        .key      (key),
        .start_o  (start_o),
        .test     (test),
        .rts      (rts),
        .rtr      (rtr),
        .v_in     (v_in),
        .obs      (obs)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_assert++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [11:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic go(input logic [ADDR_W:0] len, input logic lp);
        run_len = len;
        loop_en = lp;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    initial begin
        prog[0] = 12'h001; prog[1] = 12'h002; prog[2] = 12'h484; prog[3] = 12'h808;
        prog[4] = 12'h010; prog[5] = 12'h020; prog[6] = 12'h040; prog[7] = 12'h100;

        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; abort = 1'b0; pause = 1'b0; loop_en = 1'b0; run_len = '0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_loop", 32'(loop_cnt), 32'd0);
        chk("rst_out", 32'(outw), 32'd0);
        chk("rst_wrerr", 32'(wr_err), 32'd0);

        for (int i = 0; i < 8; i++) wr(3'(i), prog[i]);
        chk("load_wrerr", 32'(wr_err), 32'd0);

        // single pass
        go(4'd4, 1'b0);
        chk("p1_busy", 32'(busy), 32'd1);
        chk("p1_pc0", 32'(pc), 32'd0);
        chk("p1_out_pre", 32'(outw), 32'd0);
        tick(); chk("p1_w0", 32'(outw), 32'h001); chk("p1_rbtn", 32'(r_button), 32'd1);
        tick(); chk("p1_w1", 32'(outw), 32'h002); chk("p1_gbtn", 32'(g_button), 32'd1);
        tick(); chk("p1_w2", 32'(outw), 32'h484);
        chk("p1_key", 32'(key), 32'd1); chk("p1_vin", 32'(v_in), 32'd9);
        tick(); chk("p1_w3", 32'(outw), 32'h808); chk("p1_obs", 32'(obs), 32'd1);
        chk("p1_done_early", 32'(done), 32'd1);
        chk("p1_busy_off", 32'(busy), 32'd0);
        tick();
        chk("p1_out_clr", 32'(outw), 32'd0);
        chk("p1_done", 32'(done), 32'd1);
        chk("p1_pc_end", 32'(pc), 32'd3);

        // looping replay then abort
        go(4'd4, 1'b1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("lp_word", 32'(outw), 32'(prog[i % 4]));
            chk("lp_cnt", 32'(loop_cnt), 32'((i + 1) / 4));
        end
        chk("lp_busy", 32'(busy), 32'd1);
        abort = 1'b1; tick(); abort = 1'b0;
        chk("ab_busy", 32'(busy), 32'd0);
        chk("ab_done", 32'(done), 32'd0);
        chk("ab_out", 32'(outw), 32'd0);

        // pause while word 1 is showing
        go(4'd4, 1'b0);
        tick(); tick();
        chk("ps_w1", 32'(outw), 32'h002);
        pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ps_hold", 32'(outw), 32'h002);
            chk("ps_pc", 32'(pc), 32'd2);
        end
        pause = 1'b0;
        tick(); chk("ps_w2", 32'(outw), 32'h484);
        tick(); chk("ps_w3", 32'(outw), 32'h808);
        tick(); chk("ps_done", 32'(done), 32'd1);

        // write while busy is rejected
        go(4'd4, 1'b0);
        tick();
        wr(3'd2, 12'hFFF);
        chk("we_err", 32'(wr_err), 32'd1);
        chk("we_w1", 32'(outw), 32'h002);
        tick();
        chk("we_err_clr", 32'(wr_err), 32'd0);
        chk("we_w2", 32'(outw), 32'h484);
        tick(); tick();
        chk("we_done", 32'(done), 32'd1);

        // zero length start ignored, oversize length clamps
        abort = 1'b1; tick(); abort = 1'b0;
        chk("z_idle", 32'(done), 32'd0);
        go(4'd0, 1'b0);
        chk("z_busy", 32'(busy), 32'd0);
        chk("z_done", 32'(done), 32'd0);
        go(4'(DEPTH + 5), 1'b0);
        chk("cl_busy", 32'(busy), 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            tick();
            chk("cl_word", 32'(outw), 32'(prog[i]));
        end
        chk("cl_done", 32'(done), 32'd1);
        chk("cl_pc", 32'(pc), 32'(DEPTH - 1));
        tick();
        chk("cl_out_clr", 32'(outw), 32'd0);

        // reset in the middle of a looping run
        go(4'd4, 1'b1);
        for (int i = 0; i < 6; i++) tick();
        chk("mr_pc", 32'(pc), 32'd2);
        chk("mr_loop", 32'(loop_cnt), 32'd1);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("mr_pc0", 32'(pc), 32'd0);
        chk("mr_out", 32'(outw), 32'd0);
        chk("mr_loop0", 32'(loop_cnt), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_done", 32'(done), 32'd0);
        go(4'd1, 1'b0);
        tick();
        chk("mr_ram0", 32'(outw), 32'h001);
        chk("mr_done1", 32'(done), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/b10_stim_sequencer.md
Name: b10_stim_sequencer

Overview:
Synthesizable opcode replayer that sits directly upstream of the b10 voting controller and drives all of its primary inputs. A host preloads a small opcode RAM, then issues a start pulse. The block steps a program counter one word per clock, decoding each 12-bit opcode into the b10 input fields plus the __obs strobe. It replaces behavioural PC/readmemb stimulus with a cycle-exact, restartable, loopable source usable on silicon or in emulation.

Parameters:
DEPTH, 64, number of opcode words in the RAM (power of two, >= 2)
OP_W, 12, opcode width (fixed field map below; must be 12)
ADDR_W, $clog2(DEPTH), program counter / RAM address width (derived)

Ports:
clock  in  1  single system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
wr_en  in  1  RAM write strobe
wr_addr  in  ADDR_W  RAM write address
wr_data  in  12  opcode word to store
wr_err  out  1  one-cycle pulse: write rejected because block busy
start  in  1  begin replay (sampled only in IDLE or DONE)
abort  in  1  stop replay, return to IDLE
pause  in  1  freeze PC and hold outputs while in RUN
loop_en  in  1  wrap to word 0 after last word instead of finishing (sampled at start)
run_len  in  ADDR_W+1  number of words to replay (sampled at start; >DEPTH clamps to DEPTH)
busy  out  1  high in RUN
done  out  1  high (level) in DONE
pc  out  ADDR_W  current read address
loop_cnt  out  8  completed wraps, saturates at 255
r_button, g_button, key, start_o, test, rts, rtr  out  1 each  decoded b10 inputs
v_in  out  4  decoded b10 vote value
obs  out  1  decoded __obs strobe

Behaviour:
- Opcode field map: [0] r_button, [1] g_button, [2] key, [3] start_o, [4] test, [5] rts, [6] rtr, [10:7] v_in, [11] obs.
- Reset (sync): state=IDLE, pc=0, loop_cnt=0, all decoded outputs 0, busy=0, done=0, wr_err=0. RAM contents are not cleared. Reset mid-RUN behaves as abort plus counter clear.
- States are IDLE, RUN and DONE.
- IDLE/DONE + start with effective length L>0: next edge goes to RUN, pc=0, loop_cnt=0, L and loop_en latched. Start with L=0 is ignored; the state is unchanged.
- RUN, pause=0, each edge:
  - decoded outputs <= RAM[pc].
  - If pc==L-1 and loop: pc<=0 and loop_cnt++ (saturating).
  - If pc==L-1 and not loop: state<=DONE.
  - Otherwise pc<=pc+1.
  - Latency: word 0 appears on the outputs after the second edge following the start sample.
- RUN, pause=1: pc, outputs and loop_cnt all hold.
- DONE: on the first DONE edge the decoded outputs clear to 0, so the last word is visible for exactly one cycle. done stays high until start or abort. pc holds at L-1.
- abort in any state: next edge goes to IDLE with outputs 0. abort takes priority over start and pause.
- start during RUN is ignored.
- Writes:
  - Accepted in IDLE/DONE; the write is visible to a start issued on the same edge's following cycle.
  - While busy, the write is dropped and wr_err pulses for one cycle.
- The RAM read is combinational from pc, so the outputs are registered once (1-cycle register stage).

Decomposition:
- Shared package b10_stim_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - opcode bit-position constants (R_BTN_B=0 … OBS_B=11, VIN_LSB=7, VIN_MSB=10);
  - the opcode struct typedef.
- One natural sub-module: b10_stim_ram (single write port, async read, DEPTH x 12, no reset).

Test Plan:
- Load words 0..3 = 12'h001, 12'h002, 12'h484, 12'h808; run_len=4, loop_en=0; pulse start -> busy high; outputs step r_button, g_button, {key, v_in=9}, obs on consecutive cycles; then done=1 and all outputs 0; pc=3.
- Same program with loop_en=1, run 10 words' worth of cycles -> word sequence repeats 0,1,2,3,0,1,…; loop_cnt=2 after 8 words; abort -> IDLE, outputs 0, busy=0.
- Hold pause high for 3 cycles while word 1 is on the outputs -> g_button stays 1 for 4 cycles total; pc is frozen; sequence resumes with word 2.
- wr_en during RUN to address 2 -> wr_err pulses once; replay still outputs the original 12'h484.
- start with run_len=0 -> stays IDLE. run_len=DEPTH+5 -> replays exactly DEPTH words, then done.
- Assert reset mid-RUN at pc=2 -> next edge pc=0, outputs 0, loop_cnt=0, IDLE; RAM word 0 is still 12'h001 on the next run.
